// File: rtl/cfg_pkg.sv
// Shared encodings for the display configuration path: mode codes, cursor fields, cursor moves.
// Also used by the text renderer and the time/date/timer register banks.
package cfg_pkg;

    typedef enum logic [2:0] {
        MODE_NORMAL = 3'd0,
        MODE_HORA   = 3'd1,
        MODE_FECHA  = 3'd2,
        MODE_TIMER  = 3'd3
    } mode_t;

    localparam logic [1:0] LOC_LEFT  = 2'd2;
    localparam logic [1:0] LOC_MID   = 2'd1;
    localparam logic [1:0] LOC_RIGHT = 2'd0;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_NORMAL: return MODE_HORA;
            MODE_HORA:   return MODE_FECHA;
            MODE_FECHA:  return MODE_TIMER;
            default:     return MODE_NORMAL;
        endcase
    endfunction

    // Field codes count up towards the left, so a left move walks 0->1->2 and wraps.
    function automatic logic [1:0] loc_left(input logic [1:0] l);
        case (l)
            LOC_RIGHT: return LOC_MID;
            LOC_MID:   return LOC_LEFT;
            default:   return LOC_RIGHT;
        endcase
    endfunction

    function automatic logic [1:0] loc_right(input logic [1:0] l);
        case (l)
            LOC_LEFT: return LOC_MID;
            LOC_MID:  return LOC_RIGHT;
            default:  return LOC_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/blink_gen.sv
// Cursor blink phase generator: toggles every HALF cycles while enabled, held low when disabled.
// restart shows the cursor immediately and starts a fresh half-period.
module blink_gen #(
    parameter int HALF = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic blink
);

    localparam int CW = $clog2(HALF) + 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            blink <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            blink <= 1'b0;
        end else if (restart) begin
            cnt   <= '0;
            blink <= 1'b1;
        end else if (cnt == LAST) begin
            cnt   <= '0;
            blink <= ~blink;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/config_cursor_ctrl.sv
// Configuration front-end: button pulses -> mode, cursor field, blink phase and edit strobes.
// All outputs registered, one clock after the button pulse; idle timeout returns to NORMAL.
module config_cursor_ctrl
    import cfg_pkg::*;
#(
    parameter int BLINK_HALF  = 25_000_000,
    parameter int TIMEOUT_CYC = 500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [2:0] config_mode,
    output logic [1:0] LOCATION,
    output logic       BLINK,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic [2:0] edit_mode,
    output logic [1:0] edit_field
);

    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

    mode_t         state, state_nxt;
    logic [1:0]    loc, loc_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic          inc_nxt, dec_nxt, restart, activity, in_cfg, timeout;

    always_comb begin
        state_nxt = state;
        loc_nxt   = loc;
        inc_nxt   = 1'b0;
        dec_nxt   = 1'b0;
        restart   = 1'b0;
        activity  = btn_mode | btn_left | btn_right | btn_up | btn_down;
        in_cfg    = (state != MODE_NORMAL);
        // Any pulse on the expiry cycle counts as activity, so it pre-empts the timeout.
        timeout   = (TIMEOUT_CYC != 0) && in_cfg && !activity && (tcnt == T_LAST);

        if (btn_mode) begin
            state_nxt = next_mode(state);
            loc_nxt   = LOC_LEFT;
            restart   = 1'b1;
        end else if (timeout) begin
            state_nxt = MODE_NORMAL;
            loc_nxt   = LOC_LEFT;
        end else if (in_cfg) begin
            if (btn_up || btn_down) begin
                inc_nxt = btn_up & ~btn_down;
                dec_nxt = btn_down & ~btn_up;
            end else if (btn_left != btn_right) begin
                loc_nxt = btn_left ? loc_left(loc) : loc_right(loc);
                restart = 1'b1;
            end
        end

        if (TIMEOUT_CYC == 0 || activity || !in_cfg || state_nxt != state)
            tcnt_nxt = '0;
        else
            tcnt_nxt = tcnt + TW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= MODE_NORMAL;
            loc        <= LOC_LEFT;
            tcnt       <= '0;
            inc_pulse  <= 1'b0;
            dec_pulse  <= 1'b0;
            edit_mode  <= 3'd0;
            edit_field <= 2'd0;
        end else begin
            state     <= state_nxt;
            loc       <= loc_nxt;
            tcnt      <= tcnt_nxt;
            inc_pulse <= inc_nxt;
            dec_pulse <= dec_nxt;
            if (inc_nxt || dec_nxt) begin
                edit_mode  <= state;
                edit_field <= loc;
            end
        end
    end

    blink_gen #(.HALF(BLINK_HALF)) u_blink (
        .clk     (clk),
        .reset   (reset),
        .en      (state_nxt != MODE_NORMAL),
        .restart (restart),
        .blink   (BLINK)
    );

    assign config_mode = state;
    assign LOCATION    = loc;

endmodule

// File: tb/tb_config_cursor_ctrl.sv
// Directed bench for config_cursor_ctrl with BLINK_HALF=4 and TIMEOUT_CYC=20.
module tb_config_cursor_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic [2:0] config_mode, edit_mode;
    logic [1:0] LOCATION, edit_field;
    logic       BLINK, inc_pulse, dec_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    config_cursor_ctrl #(.BLINK_HALF(4), .TIMEOUT_CYC(20)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_mode    (btn_mode),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .config_mode (config_mode),
        .LOCATION    (LOCATION),
        .BLINK       (BLINK),
        .inc_pulse   (inc_pulse),
        .dec_pulse   (dec_pulse),
        .edit_mode   (edit_mode),
        .edit_field  (edit_field)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One-cycle button pulse driven on the falling edge; returns 1 time unit after the sampling edge.
    task automatic press(input logic m, input logic l, input logic r, input logic u, input logic d);
        @(negedge clk);
        btn_mode = m; btn_left = l; btn_right = r; btn_up = u; btn_down = d;
        @(posedge clk);
        #1;
        btn_mode = 0; btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        tick(3);
        check("rst_mode",  config_mode, 0);
        check("rst_loc",   LOCATION,    2);
        check("rst_blink", BLINK,       0);
        check("rst_inc",   inc_pulse,   0);
        check("rst_dec",   dec_pulse,   0);
        check("rst_emode", edit_mode,   0);
        check("rst_efld",  edit_field,  0);
        @(negedge clk);
        reset = 1'b0;

        // 1: mode sequence, 5 cycles apart
        press(1, 0, 0, 0, 0);
        check("t1_mode1", config_mode, 1);
        check("t1_loc1",  LOCATION,    2);
        check("t1_blk1",  BLINK,       1);
        tick(4);
        check("t1_blk_off", BLINK, 0);
        press(1, 0, 0, 0, 0);
        check("t1_mode2", config_mode, 2);
        check("t1_loc2",  LOCATION,    2);
        tick(4);
        press(1, 0, 0, 0, 0);
        check("t1_mode3", config_mode, 3);
        check("t1_loc3",  LOCATION,    2);
        tick(4);
        press(1, 0, 0, 0, 0);
        check("t1_mode0", config_mode, 0);
        check("t1_loc0",  LOCATION,    2);
        check("t1_blk0",  BLINK,       0);

        // 2: cursor moves in HORA
        press(1, 0, 0, 0, 0);
        check("t2_mode", config_mode, 1);
        tick(4);
        check("t2_blk_pre", BLINK, 0);
        press(0, 1, 0, 0, 0);
        check("t2_left_wrap", LOCATION, 0);
        check("t2_left_blk",  BLINK,    1);
        tick(4);
        press(0, 0, 1, 0, 0);
        check("t2_right_a", LOCATION, 2);
        check("t2_blk_a",   BLINK,    1);
        tick(4);
        press(0, 0, 1, 0, 0);
        check("t2_right_b", LOCATION, 1);
        check("t2_blk_b",   BLINK,    1);
        tick(4);
        press(0, 0, 1, 0, 0);
        check("t2_right_c", LOCATION, 0);
        check("t2_blk_c",   BLINK,    1);

        // 3: edit strobes in FECHA at the middle field
        press(1, 0, 0, 0, 0);
        check("t3_mode", config_mode, 2);
        press(0, 0, 1, 0, 0);
        check("t3_loc", LOCATION, 1);
        press(0, 0, 0, 1, 0);
        check("t3_inc",   inc_pulse,  1);
        check("t3_nodec", dec_pulse,  0);
        check("t3_emode", edit_mode,  2);
        check("t3_efld",  edit_field, 1);
        tick(1);
        check("t3_inc_drop",  inc_pulse, 0);
        check("t3_emode_hld", edit_mode, 2);
        press(0, 0, 0, 1, 1);
        check("t3_both_inc", inc_pulse, 0);
        check("t3_both_dec", dec_pulse, 0);
        press(0, 0, 0, 0, 1);
        check("t3_dec",   dec_pulse, 1);
        check("t3_noinc", inc_pulse, 0);

        // 4: blink cadence and idle timeout in TIMER
        press(1, 0, 0, 0, 0);
        check("t4_mode", config_mode, 3);
        check("t4_blk0", BLINK, 1);
        tick(3);
        check("t4_blk3", BLINK, 1);
        tick(1);
        check("t4_blk4", BLINK, 0);
        tick(4);
        check("t4_blk8", BLINK, 1);
        tick(11);
        check("t4_pre_to", config_mode, 3);
        tick(1);
        check("t4_to_mode", config_mode, 0);
        check("t4_to_blk",  BLINK,       0);
        check("t4_to_loc",  LOCATION,    2);
        check("t4_to_inc",  inc_pulse,   0);

        // 5: btn_mode wins on the timeout cycle, and over lower-priority pulses
        press(1, 0, 0, 0, 0);
        tick(19);
        check("t5_pre_to", config_mode, 1);
        press(1, 0, 0, 0, 0);
        check("t5_mode_on_to", config_mode, 2);
        tick(4);
        press(1, 0, 0, 0, 0);
        press(1, 0, 0, 0, 0);
        press(1, 0, 0, 0, 0);
        check("t5_back_h", config_mode, 1);
        press(0, 1, 0, 0, 0);
        check("t5_loc0", LOCATION, 0);
        press(1, 1, 0, 1, 0);
        check("t5_prio_mode", config_mode, 2);
        check("t5_prio_loc",  LOCATION,    2);
        check("t5_prio_inc",  inc_pulse,   0);
        check("t5_prio_dec",  dec_pulse,   0);

        // Asynchronous reset while a strobe is high
        press(0, 0, 0, 1, 0);
        check("t5_strobe", inc_pulse, 1);
        reset = 1'b1;
        #1;
        check("t5_ar_inc",   inc_pulse,   0);
        check("t5_ar_mode",  config_mode, 0);
        check("t5_ar_loc",   LOCATION,    2);
        check("t5_ar_blk",   BLINK,       0);
        check("t5_ar_emode", edit_mode,   0);
        check("t5_ar_efld",  edit_field,  0);
        @(negedge clk);
        reset = 1'b0;

        // 6: NORMAL ignores edit and cursor buttons
        press(0, 0, 0, 1, 0);
        check("t6_up_inc",  inc_pulse,   0);
        check("t6_up_mode", config_mode, 0);
        press(0, 1, 0, 0, 0);
        check("t6_left_loc", LOCATION, 2);
        press(0, 0, 0, 0, 1);
        check("t6_down_dec", dec_pulse, 0);
        press(0, 0, 1, 0, 0);
        check("t6_right_loc",  LOCATION,    2);
        check("t6_right_mode", config_mode, 0);
        check("t6_blk",        BLINK,       0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Strobe exclusivity, sampled away from the active edge.
    always @(negedge clk) begin
        if (inc_pulse && dec_pulse) begin
            n_fail++;
            $display("FAIL excl: inc_pulse=%0d dec_pulse=%0d required not both 1", inc_pulse, dec_pulse);
        end
    end

endmodule
